// File: rtl/envelope_pkg.sv
// Envelope engine shared types.
// Stage encoding, parameter selects and clamped arithmetic.
package envelope_pkg;

  typedef enum logic [2:0] {
    MUTE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    RECOVER = 3'd3,
    SUSTAIN = 3'd4,
    RELEASE = 3'd5
  } EnvelopeState_t;

  localparam logic [2:0] PARAM_L1 = 3'd0;
  localparam logic [2:0] PARAM_L2 = 3'd1;
  localparam logic [2:0] PARAM_L3 = 3'd2;
  localparam logic [2:0] PARAM_L4 = 3'd3;
  localparam logic [2:0] PARAM_R1 = 3'd4;
  localparam logic [2:0] PARAM_R2 = 3'd5;
  localparam logic [2:0] PARAM_R3 = 3'd6;
  localparam logic [2:0] PARAM_R4 = 3'd7;

  localparam int ARITH_W = 16;
  typedef logic [ARITH_W-1:0] arith_t;

  function automatic arith_t sat_add(
    input arith_t a,
    input arith_t b,
    input arith_t hi
  );
    logic [ARITH_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum > {1'b0, hi}) ? hi : sum[ARITH_W-1:0];
  endfunction

  function automatic arith_t sat_sub(
    input arith_t a,
    input arith_t b,
    input arith_t lo
  );
    logic [ARITH_W:0] dif;
    dif = {1'b0, a} - {1'b0, b};
    if (dif[ARITH_W] || (dif[ARITH_W-1:0] < lo))
      return lo;
    return dif[ARITH_W-1:0];
  endfunction

endpackage

// File: rtl/envelope_if.sv
// Slot stream, parameter write port and level output
// of the envelope engine.
interface envelope_if #(
  parameter int NUM_VOICES    = 32,
  parameter int NUM_OPERATORS = 8,
  parameter int LEVEL_WIDTH   = 8
);
  localparam int SW = $clog2(NUM_VOICES * NUM_OPERATORS);

  logic                   i_SlotValid;
  logic [SW-1:0]          i_Slot;
  logic [NUM_VOICES-1:0]  i_NoteOn;
  logic                   i_WriteEnable;
  logic [SW-1:0]          i_WriteSlot;
  logic [2:0]             i_WriteParam;
  logic [LEVEL_WIDTH-1:0] i_WriteData;
  logic                   o_Valid;
  logic [SW-1:0]          o_Slot;
  logic [LEVEL_WIDTH-1:0] o_Level;

  modport master (
    output i_SlotValid, i_Slot, i_NoteOn,
    output i_WriteEnable, i_WriteSlot,
    output i_WriteParam, i_WriteData,
    input  o_Valid, o_Slot, o_Level
  );

  modport slave (
    input  i_SlotValid, i_Slot, i_NoteOn,
    input  i_WriteEnable, i_WriteSlot,
    input  i_WriteParam, i_WriteData,
    output o_Valid, o_Slot, o_Level
  );
endinterface

// File: rtl/envelope_step.sv
// Envelope stage transition for one slot visit.
// Pure combinational: state/level in, next state/level out.
module envelope_step
  import envelope_pkg::*;
#(
  parameter int LEVEL_WIDTH = 8
) (
  input  EnvelopeState_t                state,
  input  logic [LEVEL_WIDTH-1:0]        level,
  input  logic [7:0][LEVEL_WIDTH-1:0]   params,
  input  logic                          gate,
  input  logic                          tick,
  output EnvelopeState_t                next_state,
  output logic [LEVEL_WIDTH-1:0]        next_level
);
  typedef logic [LEVEL_WIDTH-1:0] lvl_t;

  function automatic lvl_t up(
    input lvl_t a,
    input lvl_t b,
    input lvl_t hi
  );
    return LEVEL_WIDTH'(sat_add(arith_t'(a), arith_t'(b), arith_t'(hi)));
  endfunction

  function automatic lvl_t dn(
    input lvl_t a,
    input lvl_t b,
    input lvl_t lo
  );
    return LEVEL_WIDTH'(sat_sub(arith_t'(a), arith_t'(b), arith_t'(lo)));
  endfunction

  lvl_t l1, l2, l3, l4;
  lvl_t r1, r2, r3, r4;

  assign l1 = params[PARAM_L1];
  assign l2 = params[PARAM_L2];
  assign l3 = params[PARAM_L3];
  assign l4 = params[PARAM_L4];
  assign r1 = params[PARAM_R1];
  assign r2 = params[PARAM_R2];
  assign r3 = params[PARAM_R3];
  assign r4 = params[PARAM_R4];

  // Stage rules; non-tick frames hold, note-off beats target-reached.
  always_comb begin
    next_state = state;
    next_level = level;
    if (tick) begin
      unique case (state)
        MUTE: begin
          next_level = '0;
          if (gate) next_state = ATTACK;
        end
        ATTACK: begin
          next_level = up(level, r1, l1);
          if (!gate) next_state = RELEASE;
          else if (next_level == l1) next_state = DECAY;
        end
        DECAY: begin
          next_level = dn(level, r2, l2);
          if (!gate) next_state = RELEASE;
          else if (next_level == l2) next_state = RECOVER;
        end
        RECOVER: begin
          if (level < l3) next_level = up(level, r3, l3);
          else if (level > l3) next_level = dn(level, r3, l3);
          else next_level = l3;
          if (!gate) next_state = RELEASE;
          else if (next_level == l3) next_state = SUSTAIN;
        end
        SUSTAIN: begin
          next_level = l3;
          if (!gate) next_state = RELEASE;
        end
        RELEASE: begin
          if (gate) begin
            next_state = ATTACK;
          end else begin
            next_level = dn(level, r4, l4);
            if (next_level == l4) next_state = MUTE;
          end
        end
        default: begin
          next_state = MUTE;
          next_level = '0;
        end
      endcase
    end
  end
endmodule

// File: rtl/envelope_engine.sv
// Time-multiplexed envelope generator, one slot per clock.
// C0 read, C1 compute/writeback, C2 output.
module envelope_engine
  import envelope_pkg::*;
#(
  parameter int NUM_VOICES    = 32,
  parameter int NUM_OPERATORS = 8,
  parameter int LEVEL_WIDTH   = 8,
  parameter int TICK_FRAMES   = 1024
) (
  input logic       i_Clock,
  input logic       i_Reset,
  envelope_if.slave bus
);
  localparam int SLOTS = NUM_VOICES * NUM_OPERATORS;
  localparam int SW    = $clog2(SLOTS);
  localparam int VW    = $clog2(NUM_VOICES);
  localparam int FW    = (TICK_FRAMES > 1) ? $clog2(TICK_FRAMES) : 1;
  localparam logic [FW-1:0] LAST_FRAME = FW'(TICK_FRAMES - 1);
  localparam logic [SW-1:0] LAST_SLOT  = SW'(SLOTS - 1);

  typedef logic [LEVEL_WIDTH-1:0] lvl_t;
  typedef logic [7:0][LEVEL_WIDTH-1:0] prm_t;

  EnvelopeState_t state_mem [SLOTS];
  lvl_t           level_mem [SLOTS];
  prm_t           param_mem [SLOTS];

  logic [FW-1:0]  frame_cnt;

  logic           c1_valid;
  logic [SW-1:0]  c1_slot;
  logic           c1_gate;
  logic           c1_tick;
  EnvelopeState_t c1_state;
  lvl_t           c1_level;
  prm_t           c1_params;

  EnvelopeState_t nx_state;
  lvl_t           nx_level;

  // Frame counter advances after the last slot of each frame.
  always_ff @(posedge i_Clock) begin
    if (i_Reset)
      frame_cnt <= '0;
    else if (bus.i_SlotValid && (bus.i_Slot == LAST_SLOT))
      frame_cnt <= (frame_cnt == LAST_FRAME) ? '0 : frame_cnt + 1'b1;
  end

  // C0 valid flag; cleared on reset to drop in-flight work.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) c1_valid <= 1'b0;
    else         c1_valid <= bus.i_SlotValid;
  end

  // C0 registered reads of slot context and gate/tick sampling.
  always_ff @(posedge i_Clock) begin
    c1_slot   <= bus.i_Slot;
    c1_gate   <= bus.i_NoteOn[bus.i_Slot[VW-1:0]];
    c1_tick   <= (frame_cnt == LAST_FRAME);
    c1_state  <= state_mem[bus.i_Slot];
    c1_level  <= level_mem[bus.i_Slot];
    c1_params <= param_mem[bus.i_Slot];
  end

  // Parameter memory; reads in C0 see the pre-write value.
  always_ff @(posedge i_Clock) begin
    if (bus.i_WriteEnable)
      param_mem[bus.i_WriteSlot][bus.i_WriteParam] <= bus.i_WriteData;
  end

  envelope_step #(
    .LEVEL_WIDTH (LEVEL_WIDTH)
  ) u_step (
    .state      (c1_state),
    .level      (c1_level),
    .params     (c1_params),
    .gate       (c1_gate),
    .tick       (c1_tick),
    .next_state (nx_state),
    .next_level (nx_level)
  );

  // C1 writeback of slot state and level.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      for (int s = 0; s < SLOTS; s++) begin
        state_mem[s] <= MUTE;
        level_mem[s] <= '0;
      end
    end else if (c1_valid) begin
      state_mem[c1_slot] <= nx_state;
      level_mem[c1_slot] <= nx_level;
    end
  end

  // C2 output register.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      bus.o_Valid <= 1'b0;
      bus.o_Slot  <= '0;
      bus.o_Level <= '0;
    end else begin
      bus.o_Valid <= c1_valid;
      if (c1_valid) begin
        bus.o_Slot  <= c1_slot;
        bus.o_Level <= nx_level;
      end
    end
  end
endmodule

// File: tb/tb_envelope_engine.sv
// Bench for envelope_engine: two instances (tick every frame
// and every 4th frame) checked against a behavioural model.
module tb_envelope_engine;
  localparam int NV = 2;
  localparam int NO = 2;
  localparam int LW = 8;
  localparam int SL = NV * NO;
  localparam int NLOG = 22;

  localparam int S_MUTE = 0, S_ATT = 1, S_DEC = 2;
  localparam int S_REC = 3, S_SUS = 4, S_REL = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  envelope_if #(.NUM_VOICES(NV), .NUM_OPERATORS(NO), .LEVEL_WIDTH(LW)) bus0();
  envelope_if #(.NUM_VOICES(NV), .NUM_OPERATORS(NO), .LEVEL_WIDTH(LW)) bus1();

  envelope_engine #(
    .NUM_VOICES(NV), .NUM_OPERATORS(NO),
    .LEVEL_WIDTH(LW), .TICK_FRAMES(1)
  ) dut0 (
    .i_Clock(clk), .i_Reset(rst), .bus(bus0)
  );

  envelope_engine #(
    .NUM_VOICES(NV), .NUM_OPERATORS(NO),
    .LEVEL_WIDTH(LW), .TICK_FRAMES(4)
  ) dut1 (
    .i_Clock(clk), .i_Reset(rst), .bus(bus1)
  );

  typedef struct {
    bit v;
    bit z;
    int slot;
    int lvl;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   m_st [2][SL];
  int   m_lv [2][SL];
  int   m_fc [2];
  int   tfr  [2] = '{1, 4};
  int   prm  [SL][8];

  int   n_checks = 0;
  int   n_err = 0;
  int   cyc = 0;
  bit   log_en = 1'b0;
  int   log0[$];
  int   log1[$];

  function automatic int mn(int a, int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int mx(int a, int b);
    return (a > b) ? a : b;
  endfunction

  function automatic void push(int d, exp_t e);
    if (d == 0) q0.push_back(e);
    else q1.push_back(e);
  endfunction

  // One visit of slot s: apply the stage rules to the model.
  function automatic int visit(int d, int s, bit g, bit tk);
    int L, st;
    int l1, l2, l3, l4, r1, r2, r3, r4;
    L = m_lv[d][s];
    st = m_st[d][s];
    l1 = prm[s][0]; l2 = prm[s][1];
    l3 = prm[s][2]; l4 = prm[s][3];
    r1 = prm[s][4]; r2 = prm[s][5];
    r3 = prm[s][6]; r4 = prm[s][7];
    if (tk) begin
      case (st)
        S_MUTE: begin
          L = 0;
          if (g) st = S_ATT;
        end
        S_ATT: begin
          L = mn(L + r1, l1);
          if (!g) st = S_REL;
          else if (L == l1) st = S_DEC;
        end
        S_DEC: begin
          L = mx(L - r2, l2);
          if (!g) st = S_REL;
          else if (L == l2) st = S_REC;
        end
        S_REC: begin
          if (L < l3) L = mn(L + r3, l3);
          else L = mx(L - r3, l3);
          if (!g) st = S_REL;
          else if (L == l3) st = S_SUS;
        end
        S_SUS: begin
          L = l3;
          if (!g) st = S_REL;
        end
        default: begin
          if (g) st = S_ATT;
          else begin
            L = mx(mx(L - r4, 0), l4);
            if (L == l4) st = S_MUTE;
          end
        end
      endcase
    end
    m_lv[d][s] = L;
    m_st[d][s] = st;
    return L;
  endfunction

  function automatic void model_cycle(int d, bit r, bit v, int s, bit [1:0] g);
    exp_t e;
    e = '{v: 1'b0, z: 1'b0, slot: 0, lvl: 0};
    if (r) begin
      for (int i = 0; i < SL; i++) begin
        m_st[d][i] = S_MUTE;
        m_lv[d][i] = 0;
      end
      m_fc[d] = 0;
      if (d == 0) q0.delete();
      else q1.delete();
      e.z = 1'b1;
      push(d, e);
      e.z = 1'b0;
      push(d, e);
    end else if (v) begin
      e.v = 1'b1;
      e.slot = s;
      e.lvl = visit(d, s, g[s % NV], m_fc[d] == tfr[d] - 1);
      push(d, e);
      if (s == SL - 1) m_fc[d] = (m_fc[d] + 1) % tfr[d];
    end else begin
      push(d, e);
    end
  endfunction

  task automatic drive(input bit r, input bit v, input int s,
                       input bit [1:0] g, input bit we, input int ws,
                       input int wp, input int wd);
    @(negedge clk);
    rst = r;
    bus0.i_SlotValid = v;      bus1.i_SlotValid = v;
    bus0.i_Slot = 2'(s);       bus1.i_Slot = 2'(s);
    bus0.i_NoteOn = g;         bus1.i_NoteOn = g;
    bus0.i_WriteEnable = we;   bus1.i_WriteEnable = we;
    bus0.i_WriteSlot = 2'(ws); bus1.i_WriteSlot = 2'(ws);
    bus0.i_WriteParam = 3'(wp); bus1.i_WriteParam = 3'(wp);
    bus0.i_WriteData = 8'(wd); bus1.i_WriteData = 8'(wd);
    for (int d = 0; d < 2; d++) model_cycle(d, r, v, s, g);
    if (we) prm[ws][wp] = wd;
  endtask

  task automatic check_out(int d, exp_t e, logic v, logic [1:0] s,
                           logic [7:0] l);
    bit ok;
    n_checks++;
    if (e.z) ok = (v == 1'b0) && (s == 2'd0) && (l == 8'd0);
    else if (!e.v) ok = (v == 1'b0);
    else ok = (v == 1'b1) && (int'(s) == e.slot) && (int'(l) == e.lvl);
    if (!ok) begin
      n_err++;
      $display("FAIL out dut%0d cyc=%0d got v=%0b slot=%0d lvl=%02h want v=%0b slot=%0d lvl=%02h",
               d, cyc, v, s, l, e.v, e.slot, e.lvl);
    end
  endtask

  task automatic chk(string name, int got, int want);
    n_checks++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s got=%02h want=%02h", name, got, want);
    end
  endtask

  // Compare process: each output is checked two cycles after its input.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (log_en && bus0.o_Valid && bus0.o_Slot == 2'd0)
      log0.push_back(int'(bus0.o_Level));
    if (log_en && bus1.o_Valid && bus1.o_Slot == 2'd0)
      log1.push_back(int'(bus1.o_Level));
    if (q0.size() >= 2)
      check_out(0, q0.pop_front(), bus0.o_Valid, bus0.o_Slot, bus0.o_Level);
    if (q1.size() >= 2)
      check_out(1, q1.pop_front(), bus1.o_Valid, bus1.o_Slot, bus1.o_Level);
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  int exp0[NLOG] = '{'h00, 'h40, 'h80, 'hC0, 'hFF, 'hCF, 'h9F, 'h80,
                     'h90, 'hA0, 'hA0, 'hA0, 'h50, 'h50, 'h90, 'hD0,
                     'hFF, 'hCF, 'h7F, 'h2F, 'h00, 'h00};
  int exp1[NLOG] = '{'h00, 'h00, 'h00, 'h00, 'h00, 'h00, 'h00, 'h40,
                     'h40, 'h40, 'h40, 'h80, 'h80, 'h80, 'h80, 'h80,
                     'h80, 'h80, 'h80, 'hC0, 'hC0, 'hC0};
  int pv0[8] = '{'hFF, 'h80, 'hA0, 'h00, 'h40, 'h30, 'h10, 'h50};
  int pv1[8] = '{'hC0, 'h40, 'h60, 'h10, 'h20, 'h08, 'h04, 'h10};

  initial begin
    bit [1:0] g;
    int sp;
    bus0.i_SlotValid = 1'b0; bus1.i_SlotValid = 1'b0;
    bus0.i_Slot = '0;        bus1.i_Slot = '0;
    bus0.i_NoteOn = '0;      bus1.i_NoteOn = '0;
    bus0.i_WriteEnable = 0;  bus1.i_WriteEnable = 0;
    bus0.i_WriteSlot = '0;   bus1.i_WriteSlot = '0;
    bus0.i_WriteParam = '0;  bus1.i_WriteParam = '0;
    bus0.i_WriteData = '0;   bus1.i_WriteData = '0;
    for (int s = 0; s < SL; s++)
      for (int p = 0; p < 8; p++) prm[s][p] = 0;

    drive(1, 0, 0, 2'b00, 0, 0, 0, 0);
    drive(1, 0, 0, 2'b00, 0, 0, 0, 0);

    for (int i = 0; i < SL * 8; i++)
      drive(0, 1, i % SL, 2'b00, 1, i / 8, i % 8,
            ((i / 8) % NV == 0) ? pv0[i % 8] : pv1[i % 8]);

    drive(1, 0, 0, 2'b00, 0, 0, 0, 0);
    log_en = 1'b1;
    for (int f = 0; f < NLOG + 1; f++) begin
      g[0] = (f < 11) || (f >= 13 && f < 17);
      g[1] = 1'b0;
      for (int s = 0; s < SL; s++) drive(0, 1, s, g, 0, 0, 0, 0);
    end
    log_en = 1'b0;

    chk("log0_size", log0.size() >= NLOG, 1);
    chk("log1_size", log1.size() >= NLOG, 1);
    for (int i = 0; i < NLOG; i++) begin
      if (i < log0.size()) chk($sformatf("tick1_f%0d", i), log0[i], exp0[i]);
      if (i < log1.size()) chk($sformatf("tick4_f%0d", i), log1[i], exp1[i]);
    end

    drive(1, 0, 0, 2'b00, 0, 0, 0, 0);
    for (int f = 0; f < 3; f++)
      for (int s = 0; s < SL; s++) drive(0, 1, s, 2'b01, 0, 0, 0, 0);
    drive(0, 1, 0, 2'b01, 0, 0, 0, 0);
    drive(1, 1, 1, 2'b01, 0, 0, 0, 0);
    for (int f = 0; f < 4; f++)
      for (int s = 0; s < SL; s++)
        drive(0, 1, s, (f < 2) ? 2'b00 : 2'b01, 0, 0, 0, 0);

    g = 2'b00;
    sp = 0;
    for (int i = 0; i < 2500; i++) begin
      bit v, we, r;
      v = ($urandom_range(0, 9) != 0);
      we = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 399) == 0);
      if (v && sp == 0 && $urandom_range(0, 3) == 0)
        g[$urandom_range(0, NV - 1)] ^= 1'b1;
      drive(r, v, v ? sp : int'($urandom_range(0, SL - 1)), g, we,
            $urandom_range(0, SL - 1), $urandom_range(0, 7),
            $urandom_range(0, 255));
      if (v) sp = (sp + 1) % SL;
    end

    for (int i = 0; i < 4; i++) drive(0, 0, 0, g, 0, 0, 0, 0);
    @(posedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
